// File: rtl/axi4_lite_rif_bridge.sv
`default_nettype none
// ============================================================================
// axi4_lite_rif_bridge : AXI4-Lite slave to level-request register interface
// (RIF) bridge. Optional acknowledge timeout: AXI4_LITE_RIF_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module axi4_lite_rif_bridge #(
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  input  logic                        awvalid,
  output logic                        awready,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] wstrb,
  input  logic                        wvalid,
  output logic                        wready,
  output logic [1:0]                  bresp,
  output logic                        bvalid,
  input  logic                        bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   araddr,
  input  logic                        arvalid,
  output logic                        arready,
  output logic [AXI_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                  rresp,
  output logic                        rvalid,
  input  logic                        rready,
  output logic                        rif_wr_req,
  output logic [AXI_ADDR_WIDTH-1:0]   rif_waddr,
  output logic [AXI_DATA_WIDTH-1:0]   rif_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] rif_wstrb,
  input  logic                        rif_wack,
  output logic                        rif_rd_req,
  output logic [AXI_ADDR_WIDTH-1:0]   rif_raddr,
  input  logic                        rif_rack,
  input  logic [AXI_DATA_WIDTH-1:0]   rif_rdata
);

  localparam int         STRB_W      = AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64) begin : g_bad_data_width
    $error("AXI_DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                      aw_full, w_full, ar_full;
  logic                      aw_full_nxt, w_full_nxt, ar_full_nxt;
  logic                      aw_hs, w_hs, ar_hs;
  logic                      wr_done, wr_err, rd_done, rd_err;
  logic                      wr_timeout, rd_timeout;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]         w_strb_q;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  // Holding registers only load while empty, so the RIF side sees them stable.
  assign rif_wr_req = (wr_state == W_REQ);
  assign rif_waddr  = aw_addr_q;
  assign rif_wdata  = w_data_q;
  assign rif_wstrb  = w_strb_q;
  assign rif_rd_req = (rd_state == R_REQ);
  assign rif_raddr  = ar_addr_q;

`ifdef AXI4_LITE_RIF_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wr_cnt, rd_cnt;

  // Counters sit at zero outside the request states, so entry always starts at 0.
  always_ff @(posedge aclk) begin
    if (!aresetn || wr_state != W_REQ) wr_cnt <= '0;
    else                               wr_cnt <= wr_cnt + 16'd1;
    if (!aresetn || rd_state != R_REQ) rd_cnt <= '0;
    else                               rd_cnt <= rd_cnt + 16'd1;
  end

  assign wr_timeout = (wr_cnt == TO_LAST);
  assign rd_timeout = (rd_cnt == TO_LAST);
`else
  assign wr_timeout = 1'b0;
  assign rd_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------- write
  always_ff @(posedge aclk) begin
    if (!aresetn) wr_state <= W_IDLE;
    else          wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    wr_done = 1'b0;
    wr_err  = 1'b0;
    case (wr_state)
      W_IDLE: if (aw_full && w_full) wr_next = W_REQ;
      W_REQ: begin
        // Acknowledge is tested first so it wins over a simultaneous expiry.
        if (rif_wack) begin
          wr_next = W_RESP;
          wr_done = 1'b1;
        end else if (wr_timeout) begin
          wr_next = W_RESP;
          wr_done = 1'b1;
          wr_err  = 1'b1;
        end
      end
      W_RESP: if (bvalid && bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
    aw_full_nxt = wr_done ? 1'b0 : (aw_full | aw_hs);
    w_full_nxt  = wr_done ? 1'b0 : (w_full | w_hs);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      aw_full <= aw_full_nxt;
      w_full  <= w_full_nxt;
      awready <= ~aw_full_nxt;
      wready  <= ~w_full_nxt;
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (wr_done) begin
        bvalid <= 1'b1;
        bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------------- read
  always_ff @(posedge aclk) begin
    if (!aresetn) rd_state <= R_IDLE;
    else          rd_state <= rd_next;
  end

  // The AR handshake lands in a holding register first, giving reads the
  // same request latency as writes.
  always_comb begin
    rd_next = rd_state;
    rd_done = 1'b0;
    rd_err  = 1'b0;
    case (rd_state)
      R_IDLE: if (ar_full) rd_next = R_REQ;
      R_REQ: begin
        if (rif_rack) begin
          rd_next = R_RESP;
          rd_done = 1'b1;
        end else if (rd_timeout) begin
          rd_next = R_RESP;
          rd_done = 1'b1;
          rd_err  = 1'b1;
        end
      end
      R_RESP: if (rvalid && rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
    ar_full_nxt = (rd_state == R_IDLE && ar_full) ? 1'b0 : (ar_full | ar_hs);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ar_full   <= 1'b0;
      arready   <= 1'b0;
      ar_addr_q <= '0;
      rvalid    <= 1'b0;
      rresp     <= RESP_OKAY;
      rdata     <= '0;
    end else begin
      ar_full <= ar_full_nxt;
      arready <= (rd_next == R_IDLE) && !ar_full_nxt;
      if (ar_hs) ar_addr_q <= araddr;
      if (rd_done) begin
        rvalid <= 1'b1;
        rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        rdata  <= rd_err ? '0 : rif_rdata;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_rif_bridge.sv
`default_nettype none
// Testbench for axi4_lite_rif_bridge: AXI4-Lite stimulus, behavioural RIF
// responder, queue scoreboard for RIF requests and B/R responses.
module tb_axi4_lite_rif_bridge;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TB_TIMEOUT = 8;
  localparam int NOACK = 100000;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [AW-1:0] araddr = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b1;
  logic          rif_wr_req;
  logic [AW-1:0] rif_waddr;
  logic [DW-1:0] rif_wdata;
  logic [SW-1:0] rif_wstrb;
  logic          rif_wack = 1'b0;
  logic          rif_rd_req;
  logic [AW-1:0] rif_raddr;
  logic          rif_rack = 1'b0;
  logic [DW-1:0] rif_rdata = '0;

  axi4_lite_rif_bridge #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .rif_wr_req(rif_wr_req), .rif_waddr(rif_waddr), .rif_wdata(rif_wdata),
    .rif_wstrb(rif_wstrb), .rif_wack(rif_wack),
    .rif_rd_req(rif_rd_req), .rif_raddr(rif_raddr), .rif_rack(rif_rack),
    .rif_rdata(rif_rdata)
  );

  initial forever #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } wexp_t;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    r;
  } rexp_t;

  wexp_t         exp_rif_w[$];
  logic [AW-1:0] exp_rif_r[$];
  logic [1:0]    exp_b[$];
  rexp_t         exp_r[$];

  // ------------------------------------------------------- RIF responder
  int            wack_delay = 0;
  int            rack_delay = 0;
  logic [DW-1:0] rack_data = '0;
  bit            stray = 1'b0;
  int            wcyc = 0, rcyc = 0;
  int            last_wr_len = 0, last_rd_len = 0, wr_pulses = 0;
  wexp_t         held_w, we;
  logic [AW-1:0] held_ra, ra;

  initial begin
    forever begin
      @(posedge aclk); #1;
      if (rif_wr_req) begin
        if (wcyc == 0) begin
          wr_pulses++;
          held_w = '{rif_waddr, rif_wdata, rif_wstrb};
          if (exp_rif_w.size() == 0) check("rif_wr_unexpected", 64'(exp_rif_w.size()), 64'd1);
          else begin
            we = exp_rif_w.pop_front();
            check("rif_waddr", 64'(rif_waddr), 64'(we.a));
            check("rif_wdata", 64'(rif_wdata), 64'(we.d));
            check("rif_wstrb", 64'(rif_wstrb), 64'(we.s));
          end
        end else begin
          check("rif_w_stable", 64'({rif_waddr, rif_wdata, rif_wstrb}), 64'(held_w));
        end
        rif_wack = (wcyc == wack_delay);
        wcyc++;
      end else begin
        if (wcyc != 0) last_wr_len = wcyc;
        wcyc = 0;
        rif_wack = stray;
      end

      if (rif_rd_req) begin
        if (rcyc == 0) begin
          held_ra = rif_raddr;
          if (exp_rif_r.size() == 0) check("rif_rd_unexpected", 64'(exp_rif_r.size()), 64'd1);
          else begin
            ra = exp_rif_r.pop_front();
            check("rif_raddr", 64'(rif_raddr), 64'(ra));
          end
        end else begin
          check("rif_raddr_stable", 64'(rif_raddr), 64'(held_ra));
        end
        rif_rack  = (rcyc == rack_delay);
        rif_rdata = rif_rack ? rack_data : DW'($urandom());
        rcyc++;
      end else begin
        if (rcyc != 0) last_rd_len = rcyc;
        rcyc = 0;
        rif_rack  = stray;
        rif_rdata = DW'($urandom());
      end
    end
  end

  // -------------------------------------------------- response scoreboard
  logic [1:0] b_e;
  rexp_t      r_e;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) check("b_unexpected", 64'(exp_b.size()), 64'd1);
        else begin
          b_e = exp_b.pop_front();
          check("bresp", 64'(bresp), 64'(b_e));
        end
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) check("r_unexpected", 64'(exp_r.size()), 64'd1);
        else begin
          r_e = exp_r.pop_front();
          check("rdata", 64'(rdata), 64'(r_e.d));
          check("rresp", 64'(rresp), 64'(r_e.r));
        end
      end
    end
  end

  // ------------------------------------------------------ AXI drivers
  task automatic aw_send(input logic [AW-1:0] a);
    bit ok = 1'b0;
    awaddr = a; awvalid = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge aclk);
      if (awready) begin @(posedge aclk); #1; ok = 1'b1; end
    end
    awvalid = 1'b0;
    if (!ok) check("aw_handshake", 64'(awready), 64'd1);
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s);
    bit ok = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge aclk);
      if (wready) begin @(posedge aclk); #1; ok = 1'b1; end
    end
    wvalid = 1'b0;
    if (!ok) check("w_handshake", 64'(wready), 64'd1);
  endtask

  task automatic ar_send(input logic [AW-1:0] a);
    bit ok = 1'b0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge aclk);
      if (arready) begin @(posedge aclk); #1; ok = 1'b1; end
    end
    arvalid = 1'b0;
    if (!ok) check("ar_handshake", 64'(arready), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 2000) begin
      @(negedge aclk); n++;
    end
    if (n >= 2000) begin
      check("drain_pending", 64'(exp_b.size() + exp_r.size()), 64'd0);
      exp_b.delete(); exp_r.delete();
    end
    @(posedge aclk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input int aw_gap, input int w_gap, input int dly,
                          input logic [1:0] resp, input int bstall);
    int n = 0;
    wack_delay = dly;
    exp_rif_w.push_back('{a, d, s});
    exp_b.push_back(resp);
    if (bstall > 0) bready = 1'b0;
    fork
      begin
        if (aw_gap > 0) begin repeat (aw_gap) @(posedge aclk); #1; end
        aw_send(a);
        if (w_gap > aw_gap + 1) begin
          @(negedge aclk);
          check("awready_held_low", 64'(awready), 64'd0);
        end
      end
      begin
        if (w_gap > 0) begin repeat (w_gap) @(posedge aclk); #1; end
        w_send(d, s);
      end
    join
    if (bstall > 0) begin
      while (!bvalid && n < 1000) begin @(negedge aclk); n++; end
      for (int i = 0; i < bstall; i++) begin
        check("bvalid_hold", 64'(bvalid), 64'd1);
        check("bresp_hold", 64'(bresp), 64'(resp));
        @(negedge aclk);
      end
      @(posedge aclk); #1;
      bready = 1'b1;
    end
    wait_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int dly, input logic [DW-1:0] ack_d,
                         input logic [DW-1:0] exp_d, input logic [1:0] resp, input int rstall);
    int n = 0;
    rack_delay = dly;
    rack_data  = ack_d;
    exp_rif_r.push_back(a);
    exp_r.push_back('{exp_d, resp});
    if (rstall > 0) rready = 1'b0;
    ar_send(a);
    if (rstall > 0) begin
      while (!rvalid && n < 1000) begin @(negedge aclk); n++; end
      for (int i = 0; i < rstall; i++) begin
        check("rvalid_hold", 64'(rvalid), 64'd1);
        check("rdata_hold", 64'(rdata), 64'(exp_d));
        check("rresp_hold", 64'(rresp), 64'(resp));
        @(negedge aclk);
      end
      @(posedge aclk); #1;
      rready = 1'b1;
    end
    wait_idle();
  endtask

  // ------------------------------------------------------------- sequence
  int pulses0, n;

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_reqs", 64'({rif_wr_req, rif_rd_req}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("ready_before_edge", 64'({awready, wready, arready}), 64'd0);
    @(negedge aclk);
    check("ready_after_release", 64'({awready, wready, arready}), 64'b111);
    @(posedge aclk); #1;

    // AW at cycle 0, W three cycles later, immediate ack: one single-cycle request
    pulses0 = wr_pulses;
    do_write(12'h010, 32'hDEADBEEF, 4'hF, 0, 3, 0, 2'b00, 0);
    check("wr_pulse_count", 64'(wr_pulses - pulses0), 64'd1);
    check("wr_pulse_len", 64'(last_wr_len), 64'd1);

    do_write(12'hFFC, 32'h0000_0001, 4'h1, 0, 0, 2, 2'b00, 0);
    do_write(12'h004, 32'hA5A5_5A5A, 4'h6, 2, 0, 1, 2'b00, 0);
    do_write(12'h800, 32'hFFFF_FFFF, 4'h8, 0, 0, 0, 2'b00, 3);

    // minimum write latency
    wack_delay = 0;
    exp_rif_w.push_back('{12'h0A0, 32'h1357_9BDF, 4'hC});
    exp_b.push_back(2'b00);
    fork
      aw_send(12'h0A0);
      w_send(32'h1357_9BDF, 4'hC);
    join
    @(negedge aclk);
    check("wr_lat_req_n", 64'(rif_wr_req), 64'd0);
    @(negedge aclk);
    check("wr_lat_req_n1", 64'(rif_wr_req), 64'd1);
    check("wr_lat_bvalid_n1", 64'(bvalid), 64'd0);
    @(negedge aclk);
    check("wr_lat_bvalid_n2", 64'(bvalid), 64'd1);
    wait_idle();

    // minimum read latency
    rack_delay = 0;
    rack_data  = 32'hC0DE_0001;
    exp_rif_r.push_back(12'h0B0);
    exp_r.push_back('{32'hC0DE_0001, 2'b00});
    ar_send(12'h0B0);
    @(negedge aclk);
    check("rd_lat_req_n", 64'(rif_rd_req), 64'd0);
    check("rd_lat_arready_n", 64'(arready), 64'd0);
    @(negedge aclk);
    check("rd_lat_req_n1", 64'(rif_rd_req), 64'd1);
    check("rd_lat_rvalid_n1", 64'(rvalid), 64'd0);
    @(negedge aclk);
    check("rd_lat_rvalid_n2", 64'(rvalid), 64'd1);
    wait_idle();

    // late ack with response back-pressure
    do_read(12'h020, 5, 32'h1234_5678, 32'h1234_5678, 2'b00, 4);
    do_read(12'hFFF, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 2'b00, 0);

    // acknowledges outside a request state must be ignored
    stray = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("stray_bvalid", 64'(bvalid), 64'd0);
      check("stray_rvalid", 64'(rvalid), 64'd0);
    end
    @(posedge aclk); #1;
    stray = 1'b0;
    @(posedge aclk); #1;

`ifdef AXI4_LITE_RIF_TIMEOUT_EN
    do_read(12'h030, NOACK, 32'h1111_2222, 32'h0, 2'b10, 0);
    check("rd_timeout_len", 64'(last_rd_len), 64'(TB_TIMEOUT));
    do_read(12'h034, TB_TIMEOUT - 1, 32'h5555_AAAA, 32'h5555_AAAA, 2'b00, 0);
    check("rd_ack_at_expiry_len", 64'(last_rd_len), 64'(TB_TIMEOUT));
    do_write(12'h040, 32'h7777_0000, 4'h3, 0, 0, NOACK, 2'b10, 0);
    check("wr_timeout_len", 64'(last_wr_len), 64'(TB_TIMEOUT));
    do_write(12'h044, 32'h7777_1111, 4'hF, 0, 0, TB_TIMEOUT - 1, 2'b00, 0);
    check("wr_ack_at_expiry_len", 64'(last_wr_len), 64'(TB_TIMEOUT));
`else
    do_read(12'h030, 300, 32'h1111_2222, 32'h1111_2222, 2'b00, 0);
    check("rd_long_wait_len", 64'(last_rd_len), 64'd301);
    do_write(12'h040, 32'h7777_0000, 4'h3, 0, 0, 300, 2'b00, 0);
    check("wr_long_wait_len", 64'(last_wr_len), 64'd301);
`endif

    // overlapped read and write, reset pulse while both requests are pending
    wack_delay = NOACK;
    rack_delay = NOACK;
    exp_rif_w.push_back('{12'h100, 32'hCAFE_F00D, 4'hF});
    exp_rif_r.push_back(12'h200);
    fork
      aw_send(12'h100);
      w_send(32'hCAFE_F00D, 4'hF);
      ar_send(12'h200);
    join
    n = 0;
    while (!(rif_wr_req && rif_rd_req) && n < 50) begin @(negedge aclk); n++; end
    check("ovl_both_req", 64'({rif_wr_req, rif_rd_req}), 64'b11);
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("ovl_rst_reqs", 64'({rif_wr_req, rif_rd_req}), 64'd0);
    check("ovl_rst_ready", 64'({awready, wready, arready}), 64'd0);
    check("ovl_rst_valid", 64'({bvalid, rvalid}), 64'd0);
    @(negedge aclk);
    check("ovl_ready_return", 64'({awready, wready, arready}), 64'b111);
    @(posedge aclk); #1;
    do_write(12'h104, 32'h0102_0304, 4'hF, 0, 0, 0, 2'b00, 0);
    do_read(12'h204, 0, 32'hFEED_BEEF, 32'hFEED_BEEF, 2'b00, 0);

    check("rif_w_queue_empty", 64'(exp_rif_w.size()), 64'd0);
    check("rif_r_queue_empty", 64'(exp_rif_r.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/axi4_lite_rif_bridge.md
AXI4_LITE_RIF_BRIDGE -- requirements
Module: axi4_lite_rif_bridge

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, 12, address width in bits.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, 32, data width in bits (32 or 64); strobe width = AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 256, RIF acknowledge timeout in cycles (range 2..65535).
REQ-004 aclk  input  1  single clock, all logic on rising edge.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 awaddr  input  AXI_ADDR_WIDTH  write address.
REQ-007 awvalid  input  1  write address valid.
REQ-008 awready  output  1  write address ready.
REQ-009 wdata  input  AXI_DATA_WIDTH  write data.
REQ-010 wstrb  input  AXI_DATA_WIDTH/8  write byte strobes.
REQ-011 wvalid  input  1  write data valid.
REQ-012 wready  output  1  write data ready.
REQ-013 bresp  output  2  write response: OKAY 2'b00 or SLVERR 2'b10 only.
REQ-014 bvalid  output  1  write response valid.
REQ-015 bready  input  1  write response ready.
REQ-016 araddr  input  AXI_ADDR_WIDTH  read address.
REQ-017 arvalid  input  1  read address valid.
REQ-018 arready  output  1  read address ready.
REQ-019 rdata  output  AXI_DATA_WIDTH  read data.
REQ-020 rresp  output  2  read response: OKAY or SLVERR only.
REQ-021 rvalid  output  1  read data valid.
REQ-022 rready  input  1  read data ready.
REQ-023 rif_wr_req  output  1  RIF write request, level, held until acknowledge or timeout.
REQ-024 rif_waddr / rif_wdata / rif_wstrb  output  AXI_ADDR_WIDTH / AXI_DATA_WIDTH / AXI_DATA_WIDTH/8  RIF write address, data, strobes; stable while rif_wr_req is high.
REQ-025 rif_wack  input  1  RIF write acknowledge.
REQ-026 rif_rd_req  output  1  RIF read request, level, held until acknowledge or timeout.
REQ-027 rif_raddr  output  AXI_ADDR_WIDTH  RIF read address; stable while rif_rd_req is high.
REQ-028 rif_rack  input  1  RIF read acknowledge; rif_rdata is valid in the same cycle.
REQ-029 rif_rdata  input  AXI_DATA_WIDTH  RIF read data.

Function
REQ-030 AW and W SHALL be accepted independently into one-entry holding registers; awready = ~aw_full and wready = ~w_full, both registered; either channel may arrive first or both in the same cycle.
REQ-031 Write FSM states SHALL be W_IDLE, W_REQ, W_RESP. W_IDLE->W_REQ when both holding registers are full (rif_wr_req high on the next edge). W_REQ->W_RESP on rif_wack or timeout. W_RESP->W_IDLE on bvalid&bready.
REQ-032 On the W_REQ exit edge: bvalid=1; bresp=OKAY on ack, SLVERR on timeout; rif_wr_req=0; both holding registers cleared. bvalid/bresp SHALL be held stable until bready.
REQ-033 Read FSM states SHALL be R_IDLE, R_REQ, R_RESP. arready=1 only in R_IDLE. An AR handshake captures araddr and enters R_REQ (rif_rd_req=1). R_REQ->R_RESP on rif_rack (rdata<=rif_rdata, OKAY) or on timeout (rdata<=0, SLVERR). R_RESP->R_IDLE on rvalid&rready.
REQ-034 Read and write paths SHALL operate concurrently and independently; each allows at most one outstanding transaction.
REQ-035 Minimum write latency SHALL be: AW/W handshake at edge N, rif_wr_req at N+1, ack in that cycle, bvalid at N+2. Reads have the same latency.
REQ-036 rif_wack/rif_rack SHALL be ignored outside W_REQ/R_REQ. If an acknowledge arrives in the cycle the timeout expires, the acknowledge SHALL win.
REQ-037 The timeout counter SHALL clear on entry to a REQ state and expire when its count equals TIMEOUT_CYCLES-1 with no acknowledge.

Reset
REQ-038 While aresetn=0 at a clock edge: all outputs 0, both FSMs idle, holding registers empty, counters 0, and any in-flight request dropped. Ready outputs SHALL rise on the first edge after release.

Configuration
REQ-039 With AXI4_LITE_RIF_TIMEOUT_EN defined, timeouts SHALL be active per REQ-036/037.
REQ-040 Without AXI4_LITE_RIF_TIMEOUT_EN, no counter SHALL exist, REQ states wait indefinitely, SLVERR is never produced, and TIMEOUT_CYCLES is unused.

Verification
REQ-041 AW addr 0x010 at cycle 0, W 0xDEADBEEF/0xF at cycle 3, ack immediate -> one rif_wr_req pulse, waddr 0x010, bresp 00.
REQ-042 AR 0x020, rif_rack after 5 cycles with 0x12345678, rready=0 for 4 cycles -> rdata stable 0x12345678 with rresp 00 until handshake.
REQ-043 Timeout build, TIMEOUT_CYCLES=8, no rack -> rif_rd_req high exactly 8 cycles, then rresp 10, rdata 0.
REQ-044 Ack in the same cycle as timeout expiry -> OKAY response.
REQ-045 Overlapped read and write, with aresetn low for one cycle during W_REQ -> all requests drop, ready outputs return, next write completes OKAY.
